multicycle_control: RTL and testbench

//  Multi-cycle main control FSM for the RV64 subset (ld, sd, beq, add/sub/and/or, addi/ori).

---
 rtl/multicycle_control.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for a multi-cycle RV64 subset core (ld, sd, beq,
//   add/sub/and/or, addi/ori). Sequences the shared PC/IR/regfile/ALU/memory
//   datapath one instruction at a time. Outputs are Moore-decoded from the
//   state. pc_write, ir_write and instr_retired in memory states are also
//   qualified by mem_ready.
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   opcode            : IR[6:0], valid from DECODE onward
//   mem_ready         : memory completes the current access this cycle
//   pc_write/_cond    : unconditional / zero-qualified PC load
//   pc_source         : 0 = ALU result, 1 = ALUOut
//   ir_write, i_or_d  : IR load, memory address select (0 = PC, 1 = ALUOut)
//   mem_read/write    : memory strobes
//   reg_write         : register file write enable
//   mem_to_reg        : writeback select (0 = ALUOut, 1 = MDR)
//   alu_src_a/_b      : ALU operand selects
//   alu_op            : 00 add, 01 sub, 10 R-type, 11 I-type
//   instr_retired     : one pulse on the last cycle of each instruction
//   illegal_instr     : sticky illegal-opcode trap flag
//   bus_err           : sticky memory-timeout trap flag
//   state_o           : current state encoding (debug)
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic       bus_err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  localparam logic [6:0]       OP_LD     = 7'b0000011;
  localparam logic [6:0]       OP_SD     = 7'b0100011;
  localparam logic [6:0]       OP_R      = 7'b0110011;
  localparam logic [6:0]       OP_I      = 7'b0010011;
  localparam logic [6:0]       OP_BEQ    = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic             mem_state;
  logic             timeout;

  // Decoded outputs before reset gating
  logic       pc_write_c, pc_write_cond_c, pc_source_c, ir_write_c, i_or_d_c;
  logic       mem_read_c, mem_write_c, reg_write_c, mem_to_reg_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, alu_op_c;
  logic       instr_retired_c;

  always_comb begin
    mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // Completion wins over the timeout when mem_ready arrives at the limit.
    timeout   = mem_state && !mem_ready && (cnt_q == CNT_LIMIT);

    state_d         = state_q;
    illegal_d       = illegal_q;
    bus_err_d       = bus_err_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_source_c     = 1'b0;
    ir_write_c      = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    reg_write_c     = 1'b0;
    mem_to_reg_c    = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    instr_retired_c = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read_c  = !timeout;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        unique case (opcode)
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_c = !timeout;
        i_or_d_c   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c     = 1'b1;
        mem_to_reg_c    = 1'b1;
        instr_retired_c = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_c     = !timeout;
        i_or_d_c        = 1'b1;
        instr_retired_c = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = 2'b11;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c     = 1'b1;
        instr_retired_c = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 1'b1;
        instr_retired_c = 1'b1;
        state_d         = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    if (timeout) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_state && !mem_ready && (cnt_q != CNT_LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Asynchronous gating: FETCH decodes to an active mem_read, so outputs
  // must be forced low combinationally while reset is held.
  always_comb begin
    pc_write      = rst_n & pc_write_c;
    pc_write_cond = rst_n & pc_write_cond_c;
    pc_source     = rst_n & pc_source_c;
    ir_write      = rst_n & ir_write_c;
    i_or_d        = rst_n & i_or_d_c;
    mem_read      = rst_n & mem_read_c;
    mem_write     = rst_n & mem_write_c;
    reg_write     = rst_n & reg_write_c;
    mem_to_reg    = rst_n & mem_to_reg_c;
    alu_src_a     = rst_n & alu_src_a_c;
    alu_src_b     = rst_n ? alu_src_b_c : '0;
    alu_op        = rst_n ? alu_op_c : '0;
    instr_retired = rst_n & instr_retired_c;
    illegal_instr = rst_n & illegal_q;
    bus_err       = rst_n & bus_err_q;
    state_o       = rst_n ? state_q : '0;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed bench for multicycle_control. Each step checks state_o, the
//   packed control vector and the sticky flags against hand-computed values.
//   Control vector bit order, MSB first:
//   pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
//   reg_write, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], instr_retired
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_source, ir_write, i_or_d;
  logic       mem_read, mem_write, reg_write, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       instr_retired, illegal_instr, bus_err;
  logic [3:0] state_o;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  localparam logic [14:0] C_ZERO      = 15'b000000000000000;
  localparam logic [14:0] C_FETCH_RDY = 15'b100101000001000;
  localparam logic [14:0] C_FETCH_WT  = 15'b000001000001000;
  localparam logic [14:0] C_FETCH_TO  = 15'b000000000001000;
  localparam logic [14:0] C_DECODE    = 15'b000000000011000;
  localparam logic [14:0] C_MEM_ADDR  = 15'b000000000110000;
  localparam logic [14:0] C_MEM_RD    = 15'b000011000000000;
  localparam logic [14:0] C_MEM_WB    = 15'b000000011000001;
  localparam logic [14:0] C_MEM_WR_R  = 15'b000010100000001;
  localparam logic [14:0] C_MEM_WR_W  = 15'b000010100000000;
  localparam logic [14:0] C_EXEC_R    = 15'b000000000100100;
  localparam logic [14:0] C_EXEC_I    = 15'b000000000110110;
  localparam logic [14:0] C_ALU_WB    = 15'b000000010000001;
  localparam logic [14:0] C_BRANCH    = 15'b011000000100011;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic [14:0] ctl;
  assign ctl = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
                mem_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                instr_retired};

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_retired (instr_retired),
    .illegal_instr (illegal_instr),
    .bus_err       (bus_err),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are applied at the falling edge; outputs settle for 1 time unit,
  // get checked, then the bench moves on to the next falling edge.
  task automatic step(input string tag, input logic [3:0] st, input logic [14:0] c,
                      input logic [1:0] flg);
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".ctl"},   32'(ctl),     32'(c));
    chk({tag, ".flags"}, 32'({illegal_instr, bus_err}), 32'(flg));
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b0;
    step("rst0", 4'd0, C_ZERO, 2'b00);
    mem_ready = 1'b1;
    step("rst1", 4'd0, C_ZERO, 2'b00);

    // add x3,x1,x2
    rst_n  = 1'b1;
    opcode = OP_R;
    step("add.f", 4'd0, C_FETCH_RDY, 2'b00);
    step("add.d", 4'd1, C_DECODE,    2'b00);
    step("add.e", 4'd6, C_EXEC_R,    2'b00);
    step("add.w", 4'd8, C_ALU_WB,    2'b00);

    // addi
    opcode = OP_I;
    step("addi.f", 4'd0, C_FETCH_RDY, 2'b00);
    step("addi.d", 4'd1, C_DECODE,    2'b00);
    step("addi.e", 4'd7, C_EXEC_I,    2'b00);
    step("addi.w", 4'd8, C_ALU_WB,    2'b00);

    // ld with three wait cycles in MEM_RD: 8 cycles total
    opcode = OP_LD;
    step("ld.f", 4'd0, C_FETCH_RDY, 2'b00);
    step("ld.d", 4'd1, C_DECODE,    2'b00);
    step("ld.a", 4'd2, C_MEM_ADDR,  2'b00);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("ld.rw", 4'd3, C_MEM_RD, 2'b00);
    mem_ready = 1'b1;
    step("ld.r", 4'd3, C_MEM_RD, 2'b00);
    step("ld.wb", 4'd4, C_MEM_WB, 2'b00);

    // sd with one wait cycle in MEM_WR
    opcode = OP_SD;
    step("sd.f", 4'd0, C_FETCH_RDY, 2'b00);
    step("sd.d", 4'd1, C_DECODE,    2'b00);
    step("sd.a", 4'd2, C_MEM_ADDR,  2'b00);
    mem_ready = 1'b0;
    step("sd.ww", 4'd5, C_MEM_WR_W, 2'b00);
    mem_ready = 1'b1;
    step("sd.w",  4'd5, C_MEM_WR_R, 2'b00);

    // beq
    opcode = OP_BEQ;
    step("beq.f", 4'd0, C_FETCH_RDY, 2'b00);
    step("beq.d", 4'd1, C_DECODE,    2'b00);
    step("beq.b", 4'd9, C_BRANCH,    2'b00);

    // illegal opcode: trap sticks until reset
    opcode = OP_BAD;
    step("ill.f", 4'd0, C_FETCH_RDY, 2'b00);
    step("ill.d", 4'd1, C_DECODE,    2'b00);
    for (int i = 0; i < 3; i++) step("ill.t", 4'd10, C_ZERO, 2'b10);
    rst_n = 1'b0;
    step("ill.rst", 4'd0, C_ZERO, 2'b00);
    rst_n = 1'b1;
    step("ill.after", 4'd0, C_FETCH_RDY, 2'b00);

    // sd stalled in MEM_WR, reset asserted mid-access
    opcode = OP_SD;
    step("rsd.d", 4'd1, C_DECODE,   2'b00);
    step("rsd.a", 4'd2, C_MEM_ADDR, 2'b00);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("rsd.ww", 4'd5, C_MEM_WR_W, 2'b00);
    rst_n = 1'b0;
    step("rsd.rst0", 4'd0, C_ZERO, 2'b00);
    step("rsd.rst1", 4'd0, C_ZERO, 2'b00);

    // FETCH timeout; counter must restart from 0 after the reset above
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step("to.wait", 4'd0, C_FETCH_WT, 2'b00);
    step("to.limit", 4'd0, C_FETCH_TO, 2'b00);
    step("to.trap",  4'd10, C_ZERO,    2'b01);
    mem_ready = 1'b1;
    step("to.hold",  4'd10, C_ZERO,    2'b01);
    rst_n = 1'b0;
    step("to.rst", 4'd0, C_ZERO, 2'b00);

    // Completion exactly at the limit beats the timeout
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    opcode    = OP_R;
    for (int i = 0; i < 15; i++) step("lim.wait", 4'd0, C_FETCH_WT, 2'b00);
    mem_ready = 1'b1;
    step("lim.done", 4'd0, C_FETCH_RDY, 2'b00);
    step("lim.dec",  4'd1, C_DECODE,    2'b00);
    step("lim.exe",  4'd6, C_EXEC_R,    2'b00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
